// File: rtl/byte_pair_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_pair_packer
// Purpose  : Assembles a valid/ready byte stream into 16-bit words, with
//            selectable byte order per word and a flush that emits a held
//            odd byte as a padded word. Words are buffered in a small
//            circular FIFO before the output handshake.
// Ports    : clk, reset     - clock, synchronous active-high reset
//            swap_en        - 0: first byte -> [15:8], 1: first byte -> [7:0]
//            in_byte/in_valid/in_ready   - byte input handshake
//            flush          - request to emit a held odd byte, padded
//            out_word/out_partial/out_valid/out_ready - FIFO head handshake
// Revision : 1.0 - initial release
// ============================================================================
module byte_pair_packer #(
  parameter int         DEPTH    = 2,      // FIFO depth in words, 1..8
  parameter logic [7:0] PAD_BYTE = 8'h00   // fill for the empty lane on flush
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        swap_en,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic [15:0] out_word,
  output logic        out_partial,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] c_DEPTH    = CW'(DEPTH);
  localparam logic [PW-1:0] c_LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } state_t;

  // Packer state
  state_t       r_state;
  state_t       w_state_nxt;
  logic [7:0]   r_hold;
  logic         r_hold_swap;
  logic         r_flush_pend;
  logic         w_flush_pend_nxt;
  logic         w_hold_load;

  // FIFO storage: {partial, word}
  logic [16:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic        w_space;
  logic        w_in_fire;
  logic        w_pop;
  logic        w_push;
  logic [16:0] w_push_data;
  logic [16:0] w_head;

  // Handshake decode. in_ready is a function of registered state only.
  assign w_space   = (r_count < c_DEPTH);
  assign in_ready  = (r_state == ST_EMPTY) || w_space;
  assign w_in_fire = in_valid && in_ready;
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;

  // --------------------------------------------------------------------------
  // Next-state / push decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_flush_pend_nxt = r_flush_pend;
    w_hold_load      = 1'b0;
    w_push           = 1'b0;
    w_push_data      = '0;

    case (r_state)
      ST_EMPTY: begin
        // A flush with nothing held has nothing to emit and is dropped.
        w_flush_pend_nxt = 1'b0;
        if (w_in_fire) begin
          w_hold_load = 1'b1;
          w_state_nxt = ST_HALF;
        end
      end

      ST_HALF: begin
        if (w_in_fire) begin
          // A real second byte beats any outstanding flush request.
          w_push           = 1'b1;
          w_push_data      = r_hold_swap ? {1'b0, in_byte, r_hold}
                                         : {1'b0, r_hold, in_byte};
          w_state_nxt      = ST_EMPTY;
          w_flush_pend_nxt = 1'b0;
        end else if (r_flush_pend && w_space) begin
          w_push           = 1'b1;
          w_push_data      = r_hold_swap ? {1'b1, PAD_BYTE, r_hold}
                                         : {1'b1, r_hold, PAD_BYTE};
          w_state_nxt      = ST_EMPTY;
          w_flush_pend_nxt = 1'b0;
        end else if (flush) begin
          w_flush_pend_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt      = ST_EMPTY;
        w_flush_pend_nxt = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Packer state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_EMPTY;
      r_hold       <= 8'h00;
      r_hold_swap  <= 1'b0;
      r_flush_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_pend <= w_flush_pend_nxt;
      if (w_hold_load) begin
        r_hold      <= in_byte;
        r_hold_swap <= swap_en;   // byte order fixed by the first byte
      end
    end
  end

  // --------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == c_LAST_PTR) ? '0 : r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == c_LAST_PTR) ? '0 : r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_push_data;
    end
  end

  assign w_head      = r_mem[r_rptr];
  assign out_word    = out_valid ? w_head[15:0] : 16'h0000;
  assign out_partial = out_valid ? w_head[16]   : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_byte_pair_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_pair_packer
// Purpose  : Directed self-checking bench for byte_pair_packer (DEPTH=2,
//            PAD_BYTE=8'h00). Inputs change 1 ns after the rising edge and
//            outputs are sampled at the same point.
// Revision : 1.0 - initial release
// ============================================================================
module tb_byte_pair_packer;

  logic        clk;
  logic        reset;
  logic        swap_en;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [15:0] out_word;
  logic        out_partial;
  logic        out_valid;
  logic        out_ready;

  int checks;
  int errors;

  byte_pair_packer #(
    .DEPTH    (2),
    .PAD_BYTE (8'h00)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .swap_en     (swap_en),
    .in_byte     (in_byte),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .flush       (flush),
    .out_word    (out_word),
    .out_partial (out_partial),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (out_word !== 16'h0000) begin errors++; $display("FAIL rst_word got %h want 0000", out_word); end
    checks++; if (out_partial !== 1'b0) begin errors++; $display("FAIL rst_partial got %b want 0", out_partial); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1; swap_en = 1'b0;
    in_valid = 1'b1; in_byte = 8'h12; tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early got %b want 0", out_valid); end
    in_byte = 8'h34; tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", out_valid); end
    checks++; if (out_word !== 16'h1234) begin errors++; $display("FAIL basic_word got %h want 1234", out_word); end
    checks++; if (out_partial !== 1'b0) begin errors++; $display("FAIL basic_partial got %b want 0", out_partial); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got %b want 0", out_valid); end
  endtask

  task automatic test_swap();
    swap_en = 1'b1; in_valid = 1'b1; in_byte = 8'hAB; tick();
    swap_en = 1'b0; in_byte = 8'hCD; tick();
    in_valid = 1'b0;
    checks++; if (out_word !== 16'hCDAB) begin errors++; $display("FAIL swap_word got %h want cdab", out_word); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL swap_drain got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    bit seen;
    swap_en = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_byte = 8'h5A; tick();
    in_valid = 1'b0; flush = 1'b1; tick();
    flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) begin seen = 1'b1; break; end
      tick();
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL flush_timeout got %b want 1", seen); end
    checks++; if (out_word !== 16'h5A00) begin errors++; $display("FAIL flush_word got %h want 5a00", out_word); end
    checks++; if (out_partial !== 1'b1) begin errors++; $display("FAIL flush_partial got %b want 1", out_partial); end
    in_valid = 1'b1; in_byte = 8'h01; tick();
    in_byte = 8'h02; tick();
    in_valid = 1'b0;
    checks++; if (out_word !== 16'h0102) begin errors++; $display("FAIL flush_next_word got %h want 0102", out_word); end
    checks++; if (out_partial !== 1'b0) begin errors++; $display("FAIL flush_next_partial got %b want 0", out_partial); end
    tick();
    // flush with nothing held must be ignored and forgotten
    flush = 1'b1; tick();
    flush = 1'b0; tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got %b want 0", out_valid); end
    // flush coincident with a first byte: byte is held, no flush
    in_valid = 1'b1; in_byte = 8'h33; flush = 1'b1; tick();
    in_valid = 1'b0; flush = 1'b0; tick(); tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_coincident got %b want 0", out_valid); end
    in_valid = 1'b1; in_byte = 8'h44; tick();
    in_valid = 1'b0;
    checks++; if (out_word !== 16'h3344) begin errors++; $display("FAIL coincident_word got %h want 3344", out_word); end
    checks++; if (out_partial !== 1'b0) begin errors++; $display("FAIL coincident_partial got %b want 0", out_partial); end
    tick();
  endtask

  task automatic test_full();
    out_ready = 1'b0; swap_en = 1'b0; in_valid = 1'b1;
    for (int b = 1; b <= 5; b++) begin
      in_byte = 8'(b); tick();
    end
    in_byte = 8'h06;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    checks++; if (out_word !== 16'h0102) begin errors++; $display("FAIL full_head got %h want 0102", out_word); end
    tick(); tick();
    checks++; if (out_word !== 16'h0102) begin errors++; $display("FAIL full_stable got %h want 0102", out_word); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid got %b want 1", out_valid); end
    out_ready = 1'b1; tick();
    checks++; if (out_word !== 16'h0304) begin errors++; $display("FAIL full_second got %h want 0304", out_word); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_again got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_word !== 16'h0506) begin errors++; $display("FAIL full_third got %h want 0506", out_word); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_drained got %b want 0", out_valid); end
  endtask

  task automatic fill_two_plus_held();
    out_ready = 1'b0; in_valid = 1'b1;
    in_byte = 8'h11; tick();
    in_byte = 8'h22; tick();
    in_byte = 8'h33; tick();
    in_byte = 8'h44; tick();
    in_byte = 8'h55; tick();
    in_valid = 1'b0;
  endtask

  task automatic test_flush_full();
    swap_en = 1'b0;
    fill_two_plus_held();
    flush = 1'b1; tick();
    flush = 1'b0; tick(); tick();
    checks++; if (out_word !== 16'h1122) begin errors++; $display("FAIL ff_head got %h want 1122", out_word); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ff_in_ready got %b want 0", in_ready); end
    out_ready = 1'b1; tick();
    out_ready = 1'b0;
    checks++; if (out_word !== 16'h3344) begin errors++; $display("FAIL ff_after_pop got %h want 3344", out_word); end
    tick();
    checks++; if (out_word !== 16'h3344) begin errors++; $display("FAIL ff_hold got %h want 3344", out_word); end
    out_ready = 1'b1; tick();
    checks++; if (out_word !== 16'h5500) begin errors++; $display("FAIL ff_pad_word got %h want 5500", out_word); end
    checks++; if (out_partial !== 1'b1) begin errors++; $display("FAIL ff_pad_partial got %b want 1", out_partial); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ff_drained got %b want 0", out_valid); end

    // byte arriving before the slot frees cancels the flush
    fill_two_plus_held();
    flush = 1'b1; tick();
    flush = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_byte = 8'h66; tick();
    tick();
    in_valid = 1'b0;
    checks++; if (out_word !== 16'h5566) begin errors++; $display("FAIL cancel_word got %h want 5566", out_word); end
    checks++; if (out_partial !== 1'b0) begin errors++; $display("FAIL cancel_partial got %b want 0", out_partial); end
    tick(); tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cancel_no_pad got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; swap_en = 1'b0; in_valid = 1'b1;
    in_byte = 8'h01; tick();
    in_byte = 8'h02; tick();
    in_byte = 8'h03; tick();
    in_valid = 1'b0; flush = 1'b1; reset = 1'b1; tick();
    reset = 1'b0; flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b want 1", in_ready); end
    checks++; if (out_word !== 16'h0000) begin errors++; $display("FAIL mid_rst_word got %h want 0000", out_word); end
    out_ready = 1'b1; in_valid = 1'b1;
    in_byte = 8'h77; tick();
    in_byte = 8'h88; tick();
    in_valid = 1'b0;
    checks++; if (out_word !== 16'h7788) begin errors++; $display("FAIL mid_rst_pair got %h want 7788", out_word); end
    checks++; if (out_partial !== 1'b0) begin errors++; $display("FAIL mid_rst_partial got %b want 0", out_partial); end
    tick(); tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_stale got %b want 0", out_valid); end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; swap_en = 1'b0; in_byte = 8'h00; in_valid = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_swap();
    test_flush();
    test_full();
    test_flush_full();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/byte_pair_packer.md
Name: byte_pair_packer

Overview:
- Receives a serial byte stream over a valid/ready handshake and assembles consecutive byte pairs into 16-bit words.
- Byte order within each word is selectable, so the same block serves both endiannesses. With `swap_en`=1 its output equals the byte-swapped form of its `swap_en`=0 output.
- Sits upstream of 16-bit datapaths as the byte-to-word receive side of the byte-swap logic, and buffers words in a small output FIFO.

Parameters:
- `DEPTH`, 2: output FIFO depth in words. Legal range is 1..8.
- `PAD_BYTE`, 8'h00: value inserted into the missing byte lane when a partial word is flushed.

Ports:
- `clk`, input, 1: the single clock. All state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `swap_en`, input, 1: 0 means first byte goes to [15:8]; 1 means first byte goes to [7:0].
- `in_byte`, input, 8: input byte.
- `in_valid`, input, 1: `in_byte` is valid.
- `in_ready`, output, 1: block can accept `in_byte` this cycle.
- `flush`, input, 1: one-cycle request to emit any held odd byte as a padded word.
- `out_word`, output, 16: head-of-FIFO word.
- `out_partial`, output, 1: head word was produced by a flush (one lane holds `PAD_BYTE`).
- `out_valid`, output, 1: FIFO not empty.
- `out_ready`, input, 1: downstream accepts the head word.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Synchronous active-high reset on `reset`.
  - Reset takes priority over all other inputs, including mid-word and mid-flush.
  - Reset clears the hold byte, the FIFO and any pending flush, and sets the state to `EMPTY`.
- Reset values: `out_word`=16'h0000, `out_partial`=0, `out_valid`=0, `in_ready`=1.
- Transfer rules:
  - Input transfer occurs when `in_valid` && `in_ready`.
  - Output transfer occurs when `out_valid` && `out_ready`.
- State `EMPTY`: no byte held; `in_ready`=1 unconditionally.
  - Accepting a byte stores it in the hold register, latches `swap_en` as `hold_swap`, and moves to `HALF`.
- State `HALF`: one byte held; `in_ready` = (registered FIFO count < `DEPTH`).
  - Accepting a byte forms a word and pushes it with `partial`=0, then returns to `EMPTY`.
  - If `hold_swap`=0, the word is {held, new}. If `hold_swap`=1, the word is {new, held}.
  - `swap_en` is don't-care during the second byte.
- Flush:
  - A `flush` pulse in `HALF` sets `flush_pend`.
  - `flush_pend` is serviced on the first cycle that meets all of: state is `HALF`, no byte is accepted, and FIFO count < `DEPTH`.
  - On service, push {held, `PAD_BYTE`} if `hold_swap`=0, or {`PAD_BYTE`, held} if `hold_swap`=1, with `partial`=1. Then go to `EMPTY` and clear `flush_pend`.
- Flush boundary cases:
  - A byte accepted in `HALF` while `flush`/`flush_pend` is active completes a normal word (`partial`=0) and clears `flush_pend`.
  - `flush` in `EMPTY` is ignored and is not remembered.
  - This includes `flush` coincident with a byte accepted in `EMPTY`: the byte is held and no flush occurs.
- Latency and full FIFO:
  - A pushed word appears on `out_*` exactly one cycle after the accepting edge.
  - There is no combinational in-to-out path.
  - `in_ready` depends only on registered state and count, never on `out_ready`.
  - A simultaneous pop and push in the same cycle keeps the count unchanged.
  - When the FIFO is full, `in_ready`=0 in `HALF`, so no push can occur.
  - When the FIFO is empty, `out_word`=0 and `out_partial`=0.
- FIFO storage:
  - The FIFO stores 17 bits per entry (word + partial).
  - It is circular, with read/write pointers that wrap modulo `DEPTH` and a count of width clog2(`DEPTH`+1).
  - Output holds stable while `out_valid`=1 and `out_ready`=0.

Test Plan:
- `swap_en`=0, bytes 0x12, 0x34, `out_ready`=1 -> one cycle after 0x34 is accepted, `out_word`=16'h1234, `out_partial`=0, `out_valid` high for 1 cycle.
- `swap_en`=1 on byte 0xAB, then `swap_en`=0 on byte 0xCD -> `out_word`=16'hCDAB (the first byte's sampled `swap_en` governs).
- Byte 0x5A, then `flush` pulse, with `PAD_BYTE`=0x00 and `swap_en`=0 -> `out_word`=16'h5A00, `out_partial`=1. Next pair 0x01, 0x02 -> 16'h0102, `out_partial`=0.
- `DEPTH`=2, `out_ready`=0, stream 0x01..0x06 continuously:
  - 16'h0102 and 16'h0304 are buffered; 0x05 is held; `in_ready`=0 with 0x06 stalled.
  - Raise `out_ready` -> words drain in order, 0x06 is accepted, and 16'h0506 follows.
- `flush` in `HALF` while the FIFO is full -> no push until a pop frees a slot, then the padded word is pushed. A byte arriving first instead yields a normal word and cancels the flush.
- Assert `reset` in `HALF` with 1 word buffered -> next cycle `out_valid`=0, `in_ready`=1. The following pair 0x77, 0x88 yields 16'h7788, with no stale byte or pending flush.
